instr_field_queue: RTL and testbench
====================================

# instr_field_queue

Parametrised instruction prefetch queue with registered field decode at the head. It sits between memory fetch and the control unit of the multicycle MIPS datapath, replacing the flat field splitter. It buffers up to DEPTH fetched 32-bit instructions, accepts and releases them with valid/ready handshakes, and presents the head entry already split into opcode, rs, rt, rd, shamt, funct, imm16, extended immediate and jump target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- EXT_W, 32: width of the extended immediate; ≥ 32.
- clk  in  1  clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch/jump taken).
- in_valid  in  1  fetch side offers in_instr.
- in_instr  in  32  fetched instruction word.
- in_ready  out  1  queue can accept; high iff count < DEPTH.
- out_valid  out  1  head entry valid; high iff count > 0.
- out_ready  in  1  control unit consumes the head.
- opcode  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- shamt  out  5  head[10:6].
- funct  out  6  head[5:0].
- imm16  out  16  head[15:0].
- imm_ext  out  EXT_W  extended immediate, rules below.
- target  out  26  head[25:0].
- is_rtype  out  1  opcode == 6'h00 and out_valid.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push: in_valid && in_ready writes in_instr at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- Pop: out_valid && out_ready advances rd_ptr, wrapping modulo DEPTH.
- in_ready depends on count only, never on out_ready. When full, a push is refused even if a pop happens in the same cycle.
- Simultaneous push and pop, with count neither 0 nor DEPTH: count unchanged and both pointers advance.
- Push with count == 0: the entry becomes visible at the head the next cycle. There is no same-cycle bypass.
- flush has priority over push and pop in the same cycle. Pointers and count go to 0 and the offered word is dropped. in_ready stays high during the flush cycle, but the handshake is void.
- Field outputs are combinational slices of the head entry. All field outputs and is_rtype are 0 when out_valid is 0.
- imm_ext rules:
  - opcodes 6'h0C (andi), 6'h0D (ori), 6'h0E (xori): zero-extended.
  - opcode 6'h0F (lui): {imm16, 16'h0000}, zero-extended to EXT_W.
  - all other opcodes: sign-extended from imm16[15].
- count is a registered counter. It is never below 0 or above DEPTH, and it must equal (wr_ptr − rd_ptr) mod DEPTH with a full/empty disambiguation.

## Timing
- Reset values, asserted asynchronously:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_valid = 0, all fields 0, in_ready = 1.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately. The first push after reset_n deasserts is accepted on the first rising edge.
- Push-to-head latency is 1 cycle. Pop takes effect at the next edge, when the new head fields appear.
- Steady-state throughput is one instruction per cycle with in_valid and out_ready both held high and 0 < count < DEPTH.

## Structure
- Package mips_fields_pkg holds:
  - field bit positions: OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO.
  - opcode constants: OP_RTYPE = 6'h00, OP_ANDI, OP_ORI, OP_XORI, OP_LUI.
  - the imm_ext extension-select enum {EXT_SIGN, EXT_ZERO, EXT_LUI}.
- One sub-module, instr_field_split: purely combinational. It maps one 32-bit word plus a valid bit to all field outputs and imm_ext, and is reused by later pipeline stages.
- Top level: storage array, pointers, counter, handshake and flush logic.

## Test plan
- add: push 32'h012A4020 into an empty queue. One cycle later: out_valid = 1, opcode = 0, rs = 9, rt = 10, rd = 8, shamt = 0, funct = 6'h20, is_rtype = 1.
- Immediate extension: push 32'h2008FFFF, 32'h3408FFFF, 32'h3C081234 and pop each. Required imm_ext values: 32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000.
- Fill and wrap (DEPTH = 4): hold out_ready low and push 5 words. count reaches 4 and in_ready drops, so the 5th is not accepted. Then pop 2, push 2 more, pop all; words must come out in FIFO order across the pointer wrap.
- Full plus pop: at count = 4, assert in_valid and out_ready together. The pop occurs, the push is refused, and count becomes 3.
- Flush: at count = 2, assert flush with in_valid = 1 and out_ready = 1. Next cycle: count = 0, out_valid = 0, all fields 0; the offered word never appears.
- Reset mid-stream: at count = 3, pulse reset_n low between edges. Outputs go to reset values immediately, before the next edge, and the next push then reads back correctly.

Source files
------------

// File: rtl/mips_fields_pkg.sv
// MIPS instruction field positions, opcode constants and immediate-extension
// selection shared by the prefetch queue and later decode stages.
package mips_fields_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int TGT_HI   = 25;
  localparam int TGT_LO   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_LUI
  } ext_sel_e;

  // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
  function automatic ext_sel_e ext_sel_of(input logic [5:0] op);
    ext_sel_e sel;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: sel = EXT_ZERO;
      OP_LUI:                   sel = EXT_LUI;
      default:                  sel = EXT_SIGN;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter: one instruction word plus valid bit to all decode
// fields and the extended immediate; every output is zero when valid is low.
module instr_field_split
  import mips_fields_pkg::*;
#(
  parameter int EXT_W = 32
) (
  input  logic [31:0]      instr,
  input  logic             valid,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [EXT_W-1:0] imm_ext,
  output logic [25:0]      target,
  output logic             is_rtype
);

  function automatic logic [EXT_W-1:0] extend_imm(input logic [15:0] imm,
                                                   input ext_sel_e   sel);
    logic signed [15:0] imm_s;
    logic [EXT_W-1:0]   res;
    imm_s = signed'(imm);
    case (sel)
      EXT_ZERO: res = EXT_W'(imm);
      EXT_LUI:  res = EXT_W'({imm, 16'h0000});
      default:  res = EXT_W'(imm_s);
    endcase
    return res;
  endfunction

  always_comb begin
    opcode   = '0;
    rs       = '0;
    rt       = '0;
    rd       = '0;
    shamt    = '0;
    funct    = '0;
    imm16    = '0;
    imm_ext  = '0;
    target   = '0;
    is_rtype = 1'b0;
    if (valid) begin
      opcode   = instr[OPC_HI:OPC_LO];
      rs       = instr[RS_HI:RS_LO];
      rt       = instr[RT_HI:RT_LO];
      rd       = instr[RD_HI:RD_LO];
      shamt    = instr[SHAMT_HI:SHAMT_LO];
      funct    = instr[FUNCT_HI:FUNCT_LO];
      imm16    = instr[IMM_HI:IMM_LO];
      imm_ext  = extend_imm(instr[IMM_HI:IMM_LO], ext_sel_of(instr[OPC_HI:OPC_LO]));
      target   = instr[TGT_HI:TGT_LO];
      is_rtype = (instr[OPC_HI:OPC_LO] == OP_RTYPE);
    end
  end

endmodule

// File: rtl/instr_field_queue.sv
// Instruction prefetch FIFO with valid/ready on both sides and the head entry
// presented already split into decode fields.
module instr_field_queue
  import mips_fields_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EXT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [31:0]                  in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  imm16,
  output logic [EXT_W-1:0]             imm_ext,
  output logic [25:0]                  target,
  output logic                         is_rtype,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      head;
  logic             push;
  logic             pop;

  // Readiness looks at occupancy only, so a full queue refuses even alongside a pop.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; out_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  assign head = mem[rd_ptr];

  instr_field_split #(.EXT_W(EXT_W)) u_split (
    .instr    (head),
    .valid    (out_valid),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16),
    .imm_ext  (imm_ext),
    .target   (target),
    .is_rtype (is_rtype)
  );

endmodule

// File: tb/tb_instr_field_queue.sv
// Bench for instr_field_queue: directed scenarios plus randomized traffic,
// checked each cycle against a queue-based reference of accepted words.
module tb_instr_field_queue;

  localparam int DEPTH = 4;
  localparam int EXT_W = 32;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [15:0]      imm16;
  logic [EXT_W-1:0] imm_ext;
  logic [25:0]      target;
  logic             is_rtype;
  logic [CNT_W-1:0] count;

  instr_field_queue #(.DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .imm_ext   (imm_ext),
    .target    (target),
    .is_rtype  (is_rtype),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          started  = 1'b0;
  logic [31:0] mq[$];
  bit          m_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference extension computed arithmetically from the opcode rules.
  function automatic logic [31:0] ref_ext(input logic [31:0] w);
    int unsigned op;
    int unsigned imm;
    op  = w >> 26;
    imm = w & 32'h0000FFFF;
    if (op >= 12 && op <= 14) return imm;
    if (op == 15) return imm << 16;
    if (imm >= 32768) return imm + 32'hFFFF0000;
    return imm;
  endfunction

  function automatic logic [31:0] head_word();
    return {opcode, rs, rt, rd, shamt, funct};
  endfunction

  // Reference model: the queue of words the DUT should be holding.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      m_push = in_valid && (mq.size() < DEPTH);
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_push) mq.push_back(in_instr);
    end
  end

  // Monitor: compare the presented head and status against the model.
  always @(negedge clk) begin
    logic [31:0] w;
    bit          v;
    if (reset_n && started) begin
      v = (mq.size() > 0);
      w = v ? mq[0] : 32'h0;
      check("out_valid", 64'(out_valid), 64'(v));
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("head_fields", 64'(head_word()), 64'(w));
      check("imm16", 64'(imm16), 64'(w & 32'hFFFF));
      check("target", 64'(target), 64'(w & 32'h03FFFFFF));
      check("imm_ext", 64'(imm_ext), v ? 64'(ref_ext(w)) : 64'h0);
      check("is_rtype", 64'(is_rtype), 64'(v && (w >> 26) == 0));
    end
  end

  task automatic drive(input bit iv, input logic [31:0] w, input bit ordy, input bit fl);
    in_valid  = iv;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] imm_w[3] = '{32'h2008FFFF, 32'h3408FFFF, 32'h3C081234};
  logic [31:0] imm_e[3] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000};
  logic [31:0] fw[7]    = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                            32'h55555555, 32'h66666666, 32'h77777777};
  logic [31:0] order[4];

  initial begin
    reset_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    #2;
    check("rst_count", 64'(count), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_imm_ext", 64'(imm_ext), 64'h0);
    #10 reset_n = 1'b1;
    tick();
    started = 1'b1;

    // R-type add decoded one cycle after push
    drive(1, 32'h012A4020, 0, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    #2;
    check("add_valid", 64'(out_valid), 64'h1);
    check("add_opcode", 64'(opcode), 64'h0);
    check("add_rs", 64'(rs), 64'd9);
    check("add_rt", 64'(rt), 64'd10);
    check("add_rd", 64'(rd), 64'd8);
    check("add_shamt", 64'(shamt), 64'h0);
    check("add_funct", 64'(funct), 64'h20);
    check("add_rtype", 64'(is_rtype), 64'h1);
    drive(0, 32'h0, 1, 0);
    tick();

    // Immediate extension kinds
    for (int i = 0; i < 3; i++) begin
      drive(1, imm_w[i], 0, 0);
      tick();
      drive(0, 32'h0, 1, 0);
      #1;
      check("imm_ext_dir", 64'(imm_ext), 64'(imm_e[i]));
      tick();
    end

    // Fill, refuse 5th, wrap
    for (int i = 0; i < 5; i++) begin
      drive(1, fw[i], 0, 0);
      tick();
    end
    drive(0, 32'h0, 0, 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'h0);
    drive(0, 32'h0, 1, 0);
    tick();
    tick();
    drive(1, fw[5], 0, 0);
    tick();
    drive(1, fw[6], 0, 0);
    tick();
    drive(0, 32'h0, 1, 0);
    check("wrap_count", 64'(count), 64'd4);
    order = '{fw[2], fw[3], fw[5], fw[6]};
    for (int k = 0; k < 4; k++) begin
      check("wrap_order", 64'(head_word()), 64'(order[k]));
      tick();
    end
    check("wrap_empty", 64'(count), 64'h0);

    // Full plus simultaneous pop: pop happens, push refused
    for (int i = 0; i < 4; i++) begin
      drive(1, fw[i], 0, 0);
      tick();
    end
    drive(1, 32'hDEADBEEF, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    check("fullpop_count", 64'(count), 64'd3);
    check("fullpop_head", 64'(head_word()), 64'(fw[1]));

    // Flush beats push and pop
    drive(0, 32'h0, 1, 0);
    tick();
    drive(1, 32'hCAFEF00D, 1, 1);
    check("preflush_count", 64'(count), 64'd2);
    tick();
    drive(0, 32'h0, 0, 0);
    check("flush_count", 64'(count), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_fields", 64'(head_word()), 64'h0);
    check("flush_imm_ext", 64'(imm_ext), 64'h0);
    tick();
    check("flush_dropped", 64'(out_valid), 64'h0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, fw[4+i], 0, 0);
      tick();
    end
    drive(0, 32'h0, 0, 0);
    check("prereset_count", 64'(count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("async_count", 64'(count), 64'h0);
    check("async_valid", 64'(out_valid), 64'h0);
    check("async_in_ready", 64'(in_ready), 64'h1);
    check("async_fields", 64'(head_word()), 64'h0);
    check("async_imm_ext", 64'(imm_ext), 64'h0);
    #3;
    drive(1, 32'h8D090004, 0, 0);
    reset_n = 1'b1;
    tick();
    drive(0, 32'h0, 0, 0);
    check("postreset_head", 64'(head_word()), 64'h8D090004);
    check("postreset_imm", 64'(imm_ext), 64'h4);
    check("postreset_count", 64'(count), 64'd1);
    drive(0, 32'h0, 1, 0);
    tick();

    // Randomized traffic with varying drain pressure
    for (int c = 0; c < 800; c++) begin
      logic [31:0] r;
      logic [5:0]  op;
      bit          ordy;
      r = $urandom();
      case ($urandom_range(0, 5))
        0:       op = 6'h00;
        1:       op = 6'h0C;
        2:       op = 6'h0D;
        3:       op = 6'h0E;
        4:       op = 6'h0F;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ordy = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, {op, r[25:0]}, ordy, $urandom_range(0, 31) == 0);
      tick();
    end

    drive(0, 32'h0, 0, 0);
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
